// File: rtl/titan4_pkg.sv
// titan4_pkg: shared widths, types and loader states for the titan4 memory path.
package titan4_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 4;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0] len_t;
  typedef logic [DATA_WIDTH-1:0] nibble_t;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} loader_state_t;
  function automatic len_t eff_len(len_t l);
    return (l == '0 || l > len_t'(MEM_DEPTH)) ? len_t'(MEM_DEPTH) : l;
  endfunction
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: control, nibble stream and Mem write port of the program loader.
interface mem_loader_if;
  import titan4_pkg::*;
  logic start;
  len_t len;
  logic in_valid;
  nibble_t in_data;
  logic in_ready;
  logic mem_we;
  addr_t mem_addr;
  nibble_t mem_data;
  logic busy;
  logic cpu_hold;
  logic done;
  logic csum_err;
  modport slave (
    input start, len, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_data, busy, cpu_hold, done, csum_err
  );
  modport master (
    output start, len, in_valid, in_data,
    input in_ready, mem_we, mem_addr, mem_data, busy, cpu_hold, done, csum_err
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: streams nibbles into Mem from address 0 and holds the CPU until done.
// Defining LOADER_CHECKSUM_EN adds a trailing mod-16 checksum beat and csum_err.
module mem_loader
  import titan4_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_loader_if.slave bus
);
  loader_state_t state, nxt;
  len_t cnt, elen;
  logic idle_or_done, beat, last;
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LOAD = CHECK;
  nibble_t sum;
  logic err;
`else
  localparam loader_state_t AFTER_LOAD = DONE;
`endif
  always_comb begin
    idle_or_done = state == IDLE || state == DONE;
    bus.in_ready = state == LOAD || state == CHECK;
    beat = bus.in_valid && bus.in_ready;
    last = cnt == elen - 1'b1;
    bus.mem_we = state == LOAD && bus.in_valid;
    bus.mem_addr = cnt[ADDR_WIDTH-1:0];
    bus.mem_data = state == LOAD ? bus.in_data : '0;
    bus.busy = bus.in_ready;
    bus.cpu_hold = bus.in_ready;
    bus.done = state == DONE;
`ifdef LOADER_CHECKSUM_EN
    bus.csum_err = err;
`else
    bus.csum_err = 1'b0;
`endif
    nxt = state;
    if (idle_or_done && bus.start) nxt = LOAD;
    else if (state == LOAD && beat && last) nxt = AFTER_LOAD;
    else if (state == CHECK && beat) nxt = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      elen <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
      err <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (idle_or_done && bus.start) begin
        cnt <= '0;
        elen <= eff_len(bus.len);
      end else if (bus.mem_we) cnt <= cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (idle_or_done && bus.start) begin
        sum <= '0;
        err <= 1'b0;
      end else if (bus.mem_we) sum <= sum + bus.in_data;
      else if (state == CHECK && beat) err <= bus.in_data != sum;
`endif
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: vector table plus randomized loads against a queue-based model of Mem.
module tb_mem_loader;
  import titan4_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  nibble_t mem [MEM_DEPTH];
  logic [8:0] wlog [$];
  mem_loader_if bus ();
  mem_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge clk) if (bus.mem_we) begin
    mem[bus.mem_addr] <= bus.mem_data;
    wlog.push_back({bus.mem_addr, bus.mem_data});
  end
  typedef struct {
    bit st; logic [5:0] ln; bit v; logic [3:0] d;
    bit rdy; bit we; logic [4:0] a; bit by; bit dn;
  } vec_t;
  vec_t tv [$];
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_load(int len_in, nibble_t d [$], nibble_t ck, bit gaps, bit mid_start);
    int l, k, cyc, s;
    nibble_t pre3;
    l = (len_in == 0 || len_in > MEM_DEPTH) ? MEM_DEPTH : len_in;
    s = 0;
    foreach (d[i]) s += d[i];
    pre3 = mem[3];
    wlog.delete();
    bus.start = 1'b1; bus.len = 6'(len_in); bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    k = 0; cyc = 0;
    while (k < l && cyc < 500) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data = d[k];
      bus.start = mid_start && cyc == 2;
      if (mid_start && cyc == 2) bus.len = 6'd1;
      #1;
      chk("load_busy", bus.busy, 1);
      chk("load_we", bus.mem_we, bus.in_valid);
      if (bus.in_valid) begin
        chk("load_addr", bus.mem_addr, k);
        k++;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    if (cyc >= 500) chk("load_timeout", cyc, 0);
`ifdef LOADER_CHECKSUM_EN
    bus.in_valid = 1'b1; bus.in_data = ck;
    #1;
    chk("csum_ready", bus.in_ready, 1);
    chk("csum_we", bus.mem_we, 0);
    chk("csum_busy", bus.busy, 1);
    tick();
`endif
    bus.in_valid = 1'b1; bus.in_data = 4'hF;
    #1;
    chk("end_done", bus.done, 1);
    chk("end_busy", bus.busy, 0);
    chk("end_hold", bus.cpu_hold, 0);
    chk("end_ready", bus.in_ready, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_err", bus.csum_err, (s % 16) != int'(ck));
    if (l == 3) chk("csum_mem3", mem[3], pre3);
`else
    chk("csum_err_off", bus.csum_err, 0);
`endif
    tick();
    bus.in_valid = 1'b0;
    chk("write_count", wlog.size(), l);
    for (int i = 0; i < l && i < wlog.size(); i++) begin
      chk("write_entry", wlog[i], {5'(i), d[i]});
      chk("mem_data", mem[i], d[i]);
    end
  endtask
  task automatic rand_load(int len_in, bit gaps, bit mid_start);
    nibble_t d [$];
    int l, s;
    l = (len_in == 0 || len_in > MEM_DEPTH) ? MEM_DEPTH : len_in;
    s = 0;
    for (int i = 0; i < l; i++) begin
      d.push_back(4'($urandom));
      s += d[i];
    end
    run_load(len_in, d, ($urandom_range(0, 1) != 0) ? 4'(s) : 4'(s + 1), gaps, mid_start);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.len = 6'd4; bus.in_valid = 1'b1; bus.in_data = 4'hF;
    tick();
    tick();
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_data", bus.mem_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hold", bus.cpu_hold, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_csum", bus.csum_err, 0);
    rst = 1'b0; bus.start = 1'b0;
    tick();
    tv.push_back('{0, 6'd0, 1, 4'h5, 0, 0, 5'd0, 0, 0});
    tv.push_back('{1, 6'd4, 0, 4'h0, 0, 0, 5'd0, 0, 0});
    tv.push_back('{0, 6'd9, 1, 4'h1, 1, 1, 5'd0, 1, 0});
    tv.push_back('{0, 6'd9, 1, 4'h2, 1, 1, 5'd1, 1, 0});
    tv.push_back('{0, 6'd9, 1, 4'h3, 1, 1, 5'd2, 1, 0});
    tv.push_back('{0, 6'd9, 1, 4'h4, 1, 1, 5'd3, 1, 0});
`ifdef LOADER_CHECKSUM_EN
    tv.push_back('{0, 6'd9, 1, 4'hA, 1, 0, 5'd4, 1, 0});
`endif
    tv.push_back('{0, 6'd9, 1, 4'h7, 0, 0, 5'd4, 0, 1});
    foreach (tv[i]) begin
      bus.start = tv[i].st; bus.len = tv[i].ln; bus.in_valid = tv[i].v; bus.in_data = tv[i].d;
      #1;
      chk($sformatf("vec%0d_ready", i), bus.in_ready, tv[i].rdy);
      chk($sformatf("vec%0d_we", i), bus.mem_we, tv[i].we);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, tv[i].a);
      chk($sformatf("vec%0d_busy", i), bus.busy, tv[i].by);
      chk($sformatf("vec%0d_hold", i), bus.cpu_hold, tv[i].by);
      chk($sformatf("vec%0d_done", i), bus.done, tv[i].dn);
      tick();
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("vec_mem%0d", i), mem[i], i + 1);
    rand_load(0, 1, 0);
    rand_load(40, 1, 1);
    for (int n = 0; n < 4; n++) rand_load($urandom_range(1, 63), 1, n[0]);
    bus.start = 1'b1; bus.len = 6'd8; bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 4'(4'hA + i);
      tick();
    end
    bus.in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("abort_mem%0d", i), mem[i], 4'hA + i);
    run_load(2, '{4'h5, 4'h6}, 4'hB, 0, 0);
    chk("abort_mem2_kept", mem[2], 4'hC);
`ifdef LOADER_CHECKSUM_EN
    run_load(3, '{4'h9, 4'h8, 4'h7}, 4'h8, 0, 0);
    run_load(3, '{4'h9, 4'h8, 4'h7}, 4'h5, 0, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
